// File: rtl/board_engine.sv
`default_nettype none
// board_engine: tic-tac-toe board datapath (board, player, turn timer, random move, win/tie).
// Revision 1.0
module board_engine #(
  parameter int TURN_CYCLES = 500000000,
  parameter int TIMER_W     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NewGame,
  input  logic        Time,
  input  logic        ValidatePlay,
  input  logic        PlayRandom,
  input  logic        ChangeTurn,
  input  logic [3:0]  cell_sel,
  input  logic        confirm,
  output logic        TimeOut,
  output logic        Ready,
  output logic        V,
  output logic        Player,
  output logic        Win,
  output logic        Tie,
  output logic        win_player,
  output logic [17:0] board
);

  localparam logic [TIMER_W-1:0] C_LAST = TIMER_W'(TURN_CYCLES - 1);
  localparam logic [11:0] C_LINES [8] = '{
    {4'd0, 4'd1, 4'd2}, {4'd3, 4'd4, 4'd5}, {4'd6, 4'd7, 4'd8},
    {4'd0, 4'd3, 4'd6}, {4'd1, 4'd4, 4'd7}, {4'd2, 4'd5, 4'd8},
    {4'd0, 4'd4, 4'd8}, {4'd2, 4'd4, 4'd6}};

  logic [17:0]        r_board;
  logic               r_player, r_timeout, r_ready, r_v, r_win, r_tie, r_win_p;
  logic               r_armed;
  logic [TIMER_W-1:0] r_count;
  logic [3:0]         r_lfsr;
  logic               r_sync1, r_sync2, r_conf_q;

  logic [1:0]  w_cell [9];
  logic [15:0] w_empty;
  logic        w_full, w_win, w_win_p;
  logic [3:0]  w_a, w_b, w_c;
  logic [3:0]  w_start, w_idx, w_rnd_idx, w_wr_idx;
  logic [4:0]  w_sum;
  logic        w_rnd_found, w_sel_ok, w_commit_ok, w_we, w_rise;
  logic [1:0]  w_code;

  genvar gi;
  for (gi = 0; gi < 9; gi++) begin : g_cell
    assign w_cell[gi]  = r_board[2*gi +: 2];
    assign w_empty[gi] = (r_board[2*gi +: 2] == 2'b00);
  end
  // Upper bits pad the empty map so cell_sel 9..15 reads as occupied.
  assign w_empty[15:9] = '0;
  assign w_full        = ~|w_empty[8:0];

  always_comb begin
    w_win   = 1'b0;
    w_win_p = 1'b0;
    w_a     = '0;
    w_b     = '0;
    w_c     = '0;
    for (int l = 0; l < 8; l++) begin
      w_a = C_LINES[l][11:8];
      w_b = C_LINES[l][7:4];
      w_c = C_LINES[l][3:0];
      if (!w_win && !w_empty[w_a] && (w_cell[w_a] == w_cell[w_b]) && (w_cell[w_a] == w_cell[w_c])) begin
        w_win   = 1'b1;
        w_win_p = w_cell[w_a][1];
      end
    end
  end

  // Random pick: scan forward from the LFSR-derived start with wrap modulo 9.
  assign w_start = (r_lfsr < 4'd9) ? r_lfsr : (r_lfsr - 4'd9);

  always_comb begin
    w_rnd_found = 1'b0;
    w_rnd_idx   = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < 9; k++) begin
      w_sum = {1'b0, w_start} + 5'(k);
      w_idx = (w_sum >= 5'd9) ? 4'(w_sum - 5'd9) : w_sum[3:0];
      if (!w_rnd_found && w_empty[w_idx]) begin
        w_rnd_found = 1'b1;
        w_rnd_idx   = w_idx;
      end
    end
  end

  assign w_commit_ok = ~r_win & ~r_tie;
  assign w_sel_ok    = (cell_sel <= 4'd8) && w_empty[cell_sel];
  assign w_code      = {r_player, ~r_player};
  assign w_rise      = r_sync2 & ~r_conf_q;

  always_comb begin
    w_we     = 1'b0;
    w_wr_idx = cell_sel;
    if (ValidatePlay) begin
      w_we = w_commit_ok & w_sel_ok;
    end else if (PlayRandom) begin
      w_we     = w_commit_ok & w_rnd_found;
      w_wr_idx = w_rnd_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_board   <= '0;
      r_player  <= 1'b0;
      r_timeout <= 1'b0;
      r_ready   <= 1'b0;
      r_v       <= 1'b0;
      r_win     <= 1'b0;
      r_tie     <= 1'b0;
      r_win_p   <= 1'b0;
      r_armed   <= 1'b0;
      r_count   <= '0;
      r_lfsr    <= 4'b0001;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_conf_q  <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      r_sync1  <= confirm;
      r_sync2  <= r_sync1;
      r_conf_q <= r_sync2;

      if (NewGame) begin
        r_board   <= '0;
        r_player  <= 1'b0;
        r_timeout <= 1'b0;
        r_ready   <= 1'b0;
        r_v       <= 1'b0;
        r_win     <= 1'b0;
        r_tie     <= 1'b0;
        r_win_p   <= 1'b0;
        r_armed   <= 1'b0;
        r_count   <= '0;
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (w_we && (w_wr_idx == 4'(i))) r_board[2*i +: 2] <= w_code;
        end
        if (ValidatePlay || PlayRandom) r_v <= w_we;
        else if (ChangeTurn)            r_v <= 1'b0;

        if (ChangeTurn) r_player <= ~r_player;

        if (ValidatePlay || ChangeTurn) r_ready <= 1'b0;
        else if (w_rise)                r_ready <= 1'b1;

        // While armed TimeOut is already 0, so ChangeTurn only matters when idle.
        if (Time) begin
          r_count   <= '0;
          r_armed   <= 1'b1;
          r_timeout <= 1'b0;
        end else if (r_armed) begin
          if (r_count == C_LAST) begin
            r_timeout <= 1'b1;
            r_armed   <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end else if (ChangeTurn) begin
          r_timeout <= 1'b0;
        end

        r_win   <= w_win;
        r_tie   <= w_full & ~w_win;
        r_win_p <= w_win_p;
      end
    end
  end

  assign board      = r_board;
  assign Player     = r_player;
  assign TimeOut    = r_timeout;
  assign Ready      = r_ready;
  assign V          = r_v;
  assign Win        = r_win;
  assign Tie        = r_tie;
  assign win_player = r_win_p;

endmodule
`default_nettype wire

// File: tb/tb_board_engine.sv
`default_nettype none
// tb_board_engine: self-checking bench for board_engine with a behavioural game model.
// Revision 1.0
module tb_board_engine;
  localparam int TC = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic        NewGame = 1'b0, Time = 1'b0, ValidatePlay = 1'b0, PlayRandom = 1'b0, ChangeTurn = 1'b0;
  logic [3:0]  cell_sel = 4'd0;
  logic        confirm = 1'b0;
  logic        TimeOut, Ready, V, Player, Win, Tie, win_player;
  logic [17:0] board;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;
  int seq [15];

  board_engine #(.TURN_CYCLES(TC), .TIMER_W(4)) dut (
    .clk(clk), .rst(rst), .NewGame(NewGame), .Time(Time), .ValidatePlay(ValidatePlay),
    .PlayRandom(PlayRandom), .ChangeTurn(ChangeTurn), .cell_sel(cell_sel), .confirm(confirm),
    .TimeOut(TimeOut), .Ready(Ready), .V(V), .Player(Player), .Win(Win), .Tie(Tie),
    .win_player(win_player), .board(board));

  always #5 clk = ~clk;

  // Edges elapsed since reset release; selects the expected LFSR state.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else      cnt <= cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vp(input logic [3:0] s);
    cell_sel = s; ValidatePlay = 1'b1; step(); ValidatePlay = 1'b0;
  endtask
  task automatic pulse_pr();   PlayRandom = 1'b1; step(); PlayRandom = 1'b0; endtask
  task automatic pulse_ct();   ChangeTurn = 1'b1; step(); ChangeTurn = 1'b0; endtask
  task automatic pulse_ng();   NewGame = 1'b1;    step(); NewGame = 1'b0;    endtask
  task automatic pulse_time(); Time = 1'b1;       step(); Time = 1'b0;       endtask

  // Winner code (1 = X, 2 = O) of the first complete line: rows, columns, diagonals; 0 if none.
  function automatic int winner(input int b [9]);
    for (int r = 0; r < 3; r++)
      if (b[3*r] != 0 && b[3*r] == b[3*r+1] && b[3*r] == b[3*r+2]) return b[3*r];
    for (int c = 0; c < 3; c++)
      if (b[c] != 0 && b[c] == b[c+3] && b[c] == b[c+6]) return b[c];
    if (b[0] != 0 && b[0] == b[4] && b[0] == b[8]) return b[0];
    if (b[2] != 0 && b[2] == b[4] && b[2] == b[6]) return b[2];
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    NewGame = 1'b1; Time = 1'b1; ValidatePlay = 1'b1; confirm = 1'b1;
    step(); step();
    n_tests++;
    if ({TimeOut, Ready, V, Player, Win, Tie, win_player} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000000", {TimeOut, Ready, V, Player, Win, Tie, win_player});
    end
    n_tests++;
    if (board !== 18'h0) begin n_fail++; $display("FAIL reset_board: got %h want 0", board); end
    NewGame = 1'b0; Time = 1'b0; ValidatePlay = 1'b0; confirm = 1'b0;
    rst = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_timer();
    pulse_time();
    for (int e = 0; e < TC; e++) begin
      n_tests++;
      if (TimeOut !== 1'b0) begin n_fail++; $display("FAIL timer_early_e%0d: TimeOut=%b want 0", e, TimeOut); end
      if (e < TC - 1) step();
    end
    step();
    n_tests++;
    if (TimeOut !== 1'b1) begin n_fail++; $display("FAIL timer_expire: TimeOut=%b want 1", TimeOut); end
    repeat (3) step();
    n_tests++;
    if (TimeOut !== 1'b1) begin n_fail++; $display("FAIL timer_hold: TimeOut=%b want 1", TimeOut); end

    pulse_time();
    n_tests++;
    if (TimeOut !== 1'b0) begin n_fail++; $display("FAIL timer_restart_clr: TimeOut=%b want 0", TimeOut); end
    repeat (4) step();
    pulse_time();
    for (int e = 5; e < 13; e++) begin
      n_tests++;
      if (TimeOut !== 1'b0) begin n_fail++; $display("FAIL timer_retrig_e%0d: TimeOut=%b want 0", e, TimeOut); end
      step();
    end
    n_tests++;
    if (TimeOut !== 1'b1) begin n_fail++; $display("FAIL timer_retrig_expire: TimeOut=%b want 1", TimeOut); end

    pulse_ct();
    n_tests++;
    if (TimeOut !== 1'b0 || Player !== 1'b1) begin
      n_fail++; $display("FAIL changeturn_clr: TimeOut=%b Player=%b want 0 1", TimeOut, Player);
    end
    pulse_ct();

    pulse_time();
    repeat (TC) step();
    n_tests++;
    if (TimeOut !== 1'b1) begin n_fail++; $display("FAIL timer_pre_rst: TimeOut=%b want 1", TimeOut); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (TimeOut !== 1'b0) begin n_fail++; $display("FAIL async_rst: TimeOut=%b want 0", TimeOut); end
    #1 rst = 1'b1;
    pulse_time();
    repeat (3) step();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2 * TC) step();
    n_tests++;
    if (TimeOut !== 1'b0) begin n_fail++; $display("FAIL rst_disarm: TimeOut=%b want 0", TimeOut); end
  endtask

  task automatic test_confirm_validate();
    pulse_ng();
    confirm = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_tests++;
      if (Ready !== (c == 3)) begin n_fail++; $display("FAIL ready_lat_c%0d: Ready=%b want %b", c, Ready, (c == 3)); end
    end
    pulse_vp(4'd4);
    n_tests++;
    if (V !== 1'b1 || board[9:8] !== 2'b01 || Ready !== 1'b0) begin
      n_fail++; $display("FAIL validate_c4: V=%b cell4=%b Ready=%b want 1 01 0", V, board[9:8], Ready);
    end
    repeat (4) step();
    n_tests++;
    if (Ready !== 1'b0) begin n_fail++; $display("FAIL ready_level: Ready=%b want 0", Ready); end
    confirm = 1'b0;
  endtask

  task automatic test_invalid();
    logic [17:0] b;
    b = 18'h00100;
    pulse_vp(4'd4);
    n_tests++;
    if (V !== 1'b0 || board !== b) begin n_fail++; $display("FAIL occupied: V=%b board=%h want 0 %h", V, board, b); end
    pulse_vp(4'd12);
    n_tests++;
    if (V !== 1'b0 || board !== b) begin n_fail++; $display("FAIL out_of_range: V=%b board=%h want 0 %h", V, board, b); end
  endtask

  task automatic test_win();
    logic [17:0] b;
    pulse_ng();
    pulse_vp(4'd0); pulse_ct(); pulse_vp(4'd3); pulse_ct();
    pulse_vp(4'd1); pulse_ct(); pulse_vp(4'd4); pulse_ct();
    pulse_vp(4'd2);
    n_tests++;
    if (Win !== 1'b0) begin n_fail++; $display("FAIL win_latency: Win=%b want 0", Win); end
    step();
    n_tests++;
    if (Win !== 1'b1 || win_player !== 1'b0 || Tie !== 1'b0) begin
      n_fail++; $display("FAIL win_row0: Win=%b wp=%b Tie=%b want 1 0 0", Win, win_player, Tie);
    end
    b = 18'h00aa5 | 18'h0;
    b = {2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    pulse_vp(4'd5);
    n_tests++;
    if (V !== 1'b0 || board !== b) begin n_fail++; $display("FAIL after_win: V=%b board=%h want 0 %h", V, board, b); end
  endtask

  task automatic test_random_tie();
    int          xs [5] = '{0, 1, 5, 6, 8};
    int          os [3] = '{2, 3, 4};
    logic [17:0] b;
    pulse_ng();
    foreach (xs[i]) pulse_vp(4'(xs[i]));
    pulse_ct();
    foreach (os[i]) pulse_vp(4'(os[i]));
    pulse_pr();
    b = {2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    n_tests++;
    if (V !== 1'b1 || board !== b) begin n_fail++; $display("FAIL random_last: V=%b board=%h want 1 %h", V, board, b); end
    step();
    n_tests++;
    if (Win !== 1'b0 || Tie !== 1'b1) begin n_fail++; $display("FAIL tie: Win=%b Tie=%b want 0 1", Win, Tie); end
    pulse_pr();
    n_tests++;
    if (V !== 1'b0 || board !== b) begin n_fail++; $display("FAIL random_full: V=%b board=%h want 0 %h", V, board, b); end
  endtask

  task automatic test_priority();
    pulse_ng();
    cell_sel = 4'd0; ValidatePlay = 1'b1; PlayRandom = 1'b1;
    step();
    ValidatePlay = 1'b0; PlayRandom = 1'b0;
    n_tests++;
    if (V !== 1'b1 || board !== 18'h1) begin n_fail++; $display("FAIL vp_beats_pr: V=%b board=%h want 1 00001", V, board); end
    ValidatePlay = 1'b1; PlayRandom = 1'b1;
    step();
    ValidatePlay = 1'b0; PlayRandom = 1'b0;
    n_tests++;
    if (V !== 1'b0 || board !== 18'h1) begin n_fail++; $display("FAIL pr_ignored: V=%b board=%h want 0 00001", V, board); end
    pulse_ct();
    NewGame = 1'b1; ValidatePlay = 1'b1; ChangeTurn = 1'b1; cell_sel = 4'd1;
    step();
    NewGame = 1'b0; ValidatePlay = 1'b0; ChangeTurn = 1'b0;
    n_tests++;
    if (board !== 18'h0 || V !== 1'b0 || Player !== 1'b0) begin
      n_fail++; $display("FAIL newgame_prio: board=%h V=%b Player=%b want 0 0 0", board, V, Player);
    end
  endtask

  task automatic test_random();
    int          mb [9];
    bit          mp, mv, mw, mt, mwp, ok, full, vp, pr, ct, ng, found;
    int          a, s, lf, st, nw, idx;
    logic [17:0] eb;
    pulse_ng();
    foreach (mb[i]) mb[i] = 0;
    mp = 0; mv = 0; mw = 0; mt = 0; mwp = 0;
    for (int it = 0; it < 400; it++) begin
      a  = $urandom_range(0, 19);
      s  = $urandom_range(0, 11);
      vp = (a < 8) || (a == 12);
      pr = (a >= 8 && a < 13);
      ct = (a >= 13 && a < 16);
      ng = (a == 19);
      lf = seq[cnt % 15];
      st = (lf < 9) ? lf : lf - 9;
      ok = !mw && !mt;
      nw = winner(mb);
      full = 1;
      foreach (mb[i]) if (mb[i] == 0) full = 0;
      if (ng) begin
        foreach (mb[i]) mb[i] = 0;
        mp = 0; mv = 0; mw = 0; mt = 0; mwp = 0;
      end else begin
        if (vp) begin
          if (ok && s <= 8 && mb[s] == 0) begin mb[s] = mp ? 2 : 1; mv = 1; end
          else mv = 0;
        end else if (pr) begin
          found = 0; idx = 0;
          for (int k = 0; k < 9; k++)
            if (!found && mb[(st + k) % 9] == 0) begin found = 1; idx = (st + k) % 9; end
          if (ok && found) begin mb[idx] = mp ? 2 : 1; mv = 1; end
          else mv = 0;
        end else if (ct) mv = 0;
        if (ct) mp = !mp;
        mw  = (nw != 0);
        mt  = full && (nw == 0);
        mwp = (nw == 2);
      end
      cell_sel = 4'(s); ValidatePlay = vp; PlayRandom = pr; ChangeTurn = ct; NewGame = ng;
      step();
      ValidatePlay = 0; PlayRandom = 0; ChangeTurn = 0; NewGame = 0;
      for (int i = 0; i < 9; i++) eb[2*i +: 2] = 2'(mb[i]);
      n_tests++;
      if (board !== eb || V !== mv || Player !== mp || Win !== mw || Tie !== mt || (mw && win_player !== mwp)) begin
        n_fail++;
        $display("FAIL rand_it%0d: board=%h V=%b P=%b W=%b T=%b wp=%b want %h %b %b %b %b %b",
                 it, board, V, Player, Win, Tie, win_player, eb, mv, mp, mw, mt, mwp);
      end
    end
  endtask

  initial begin
    seq[0] = 1;
    for (int i = 1; i < 15; i++)
      seq[i] = ((seq[i-1] << 1) & 15) | (((seq[i-1] >> 3) ^ (seq[i-1] >> 2)) & 1);
    test_reset();
    test_timer();
    test_confirm_validate();
    test_invalid();
    test_win();
    test_random_tie();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
